// File: rtl/sort_pkg.sv
// sort_pkg: shared constants and types for the max-sort cascade.
//   M  - keys per frame (width of the sort array)
//   N  - key width in bits
// Types: key_t, frame_t (M x N packed, slot 0 in the low bits), count_t,
// idx_t and the loader state enum. M must be at least 2.
package sort_pkg;

  localparam int M     = 8;
  localparam int N     = 16;
  localparam int IDX_W = $clog2(M);
  localparam int CNT_W = $clog2(M + 1);

  typedef logic [N-1:0]         key_t;
  typedef logic [M-1:0][N-1:0]  frame_t;
  typedef logic [CNT_W-1:0]     count_t;
  typedef logic [IDX_W-1:0]     idx_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } loader_state_t;

endpackage

// File: rtl/sort_loader_if.sv
// sort_loader_if: key stream in, frame out for the sort_loader.
//   i_valid/i_key/i_last : key source -> loader (held stable until accepted)
//   o_ready              : loader -> source, key accepted when i_valid && o_ready
//   o_chi/o_count        : packed frame and number of real keys in it
//   o_enable             : one-cycle pulse marking o_chi/o_count valid
// Modports: master = key source / frame consumer side, slave = loader.
interface sort_loader_if;
  import sort_pkg::*;

  logic   i_valid;
  key_t   i_key;
  logic   i_last;
  logic   o_ready;
  frame_t o_chi;
  count_t o_count;
  logic   o_enable;

  modport master (
    output i_valid, i_key, i_last,
    input  o_ready, o_chi, o_count, o_enable
  );

  modport slave (
    input  i_valid, i_key, i_last,
    output o_ready, o_chi, o_count, o_enable
  );

endinterface

// File: rtl/sort_loader.sv
// sort_loader: front-end frame assembler for the max-sort cascade.
// Packs up to M keys from a valid/ready stream into one M x N frame and
// issues it with a single-cycle o_enable pulse. Short frames (ended by
// i_last) are zero-padded; MIN_GAP idle cycles follow every issue.
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - sort_loader_if.slave (i_valid, i_key, i_last, o_ready,
//            o_chi, o_count, o_enable)
// Parameters:
//   MIN_GAP - idle cycles after each issue before o_ready returns (0..15)
// Build option:
//   SORT_LOADER_INVERT_EN - store ~i_key so the cascade yields ascending
//                           order; pads stay zero.
//
// state | meaning
// FILL  | o_ready high, collecting keys into the buffer
// ISSUE | o_enable high for one cycle, frame presented on o_chi
// GAP   | o_ready held low for MIN_GAP cycles
module sort_loader
  import sort_pkg::*;
#(
  parameter int MIN_GAP = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  sort_loader_if.slave bus
);

  localparam idx_t       IDX_LAST = idx_t'(M - 1);
  localparam logic [3:0] GAP_LAST = 4'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

  loader_state_t state_q, state_nxt;
  idx_t          idx_q, idx_nxt;
  logic [3:0]    gap_q, gap_nxt;
  logic          ready_q;
  frame_t        buf_q;
  frame_t        chi_q;
  count_t        cnt_q;
  logic          en_q;

  logic          accept;
  logic          issue;
  key_t          key_store;
  count_t        frame_cnt;
  frame_t        frame_nxt;

`ifdef SORT_LOADER_INVERT_EN
  assign key_store = ~bus.i_key;
`else
  assign key_store = bus.i_key;
`endif

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    gap_nxt   = gap_q;
    accept    = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      FILL: begin
        accept = bus.i_valid && ready_q;
        if (accept) begin
          idx_nxt = idx_q + idx_t'(1);
          if ((idx_q == IDX_LAST) || bus.i_last) begin
            issue     = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        idx_nxt   = '0;
        gap_nxt   = '0;
        state_nxt = (MIN_GAP > 0) ? GAP : FILL;
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_nxt = FILL;
        else                   gap_nxt   = gap_q + 4'd1;
      end
      default: state_nxt = FILL;
    endcase
  end

  // o_ready is registered so it stays low through the reset-release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      gap_q   <= gap_nxt;
      ready_q <= (state_nxt == FILL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (accept) begin
      buf_q[idx_q] <= key_store;
    end
  end

  // The closing key is still in flight to the buffer on the issue edge, so
  // it is merged here; slots past the count are forced to zero so stale
  // keys from an earlier, longer frame never escape.
  always_comb begin
    frame_cnt = count_t'(idx_q) + count_t'(1);
    frame_nxt = '0;
    for (int k = 0; k < M; k++) begin
      if (k < int'(frame_cnt)) begin
        frame_nxt[k] = (k == int'(idx_q)) ? key_store : buf_q[k];
      end else begin
        frame_nxt[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chi_q <= '0;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q <= issue;
      if (issue) begin
        chi_q <= frame_nxt;
        cnt_q <= frame_cnt;
      end
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_chi    = chi_q;
  assign bus.o_count  = cnt_q;
  assign bus.o_enable = en_q;

endmodule
